worldmap_port_arbiter: RTL and testbench

- Shares the single world_map read port (port A) between two rojobot instances (player A and player B) on the 75 MHz video/bot clock domain.
- Round-robin arbitration with registered grant.
- Tracks in-flight reads through a RD_LATENCY-deep tag pipeline and returns each read's data to the requester that issued it.
- Sits between the rojobot worldmap_addr/worldmap_data pairs and world_map.addra/douta.

---
 rtl/worldmap_port_arbiter_if.sv | 15 +
 rtl/worldmap_port_arbiter.sv | 114 +++++++++++
 tb/tb_worldmap_port_arbiter.sv | 249 ++++++++++++++++++++++++
 3 files changed

// File: rtl/worldmap_port_arbiter_if.sv
// Read handshake between one rojobot and the world-map port arbiter.
// The requester drives req/addr; the arbiter returns grant, data and data-valid.
interface worldmap_port_arbiter_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 2
);
    logic              req;
    logic [ADDR_W-1:0] addr;
    logic              gnt;
    logic [DATA_W-1:0] rdata;
    logic              rvalid;

    modport master (output req, output addr, input gnt, input rdata, input rvalid);
    modport slave  (input req, input addr, output gnt, output rdata, output rvalid);
endinterface

// File: rtl/worldmap_port_arbiter.sv
// Round-robin sharing of the world_map read port between two rojobots, with a
// tag pipeline that routes each read's data back to the player that issued it.
module worldmap_port_arbiter #(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 2,
    parameter int RD_LATENCY = 1
) (
    input  logic                   clock,
    input  logic                   reset_n,
    worldmap_port_arbiter_if.slave port_a,
    worldmap_port_arbiter_if.slave port_b,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic                   mem_en,
    input  logic [DATA_W-1:0]      mem_rdata
);
    localparam int STAGES = RD_LATENCY + 1;

    typedef enum logic {
        LAST_A = 1'b0,
        LAST_B = 1'b1
    } last_gnt_t;

    last_gnt_t         last_gnt_reg, last_gnt_next;
    logic              gnt_a_reg, gnt_a_next;
    logic              gnt_b_reg, gnt_b_next;
    logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
    logic              mem_en_reg;
    logic              elig_a, elig_b;

    // Tag id 1 marks a read issued for player B.
    logic [STAGES-1:0] tag_valid_reg;
    logic [STAGES-1:0] tag_id_reg;
    logic              ret_a, ret_b;

    logic [DATA_W-1:0] rdata_a_reg, rdata_b_reg;
    logic              rvalid_a_reg, rvalid_b_reg;

    // A requester granted this cycle sits out the next arbitration.
    assign elig_a = port_a.req && !gnt_a_reg;
    assign elig_b = port_b.req && !gnt_b_reg;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            last_gnt_reg <= LAST_B;
            gnt_a_reg    <= 1'b0;
            gnt_b_reg    <= 1'b0;
            mem_addr_reg <= '0;
            mem_en_reg   <= 1'b0;
        end else begin
            last_gnt_reg <= last_gnt_next;
            gnt_a_reg    <= gnt_a_next;
            gnt_b_reg    <= gnt_b_next;
            mem_addr_reg <= mem_addr_next;
            mem_en_reg   <= gnt_a_next | gnt_b_next;
        end
    end

    always_comb begin
        last_gnt_next = last_gnt_reg;
        gnt_a_next    = 1'b0;
        gnt_b_next    = 1'b0;
        mem_addr_next = mem_addr_reg;
        if (elig_a && (!elig_b || last_gnt_reg == LAST_B)) begin
            gnt_a_next    = 1'b1;
            mem_addr_next = port_a.addr;
            last_gnt_next = LAST_A;
        end else if (elig_b) begin
            gnt_b_next    = 1'b1;
            mem_addr_next = port_b.addr;
            last_gnt_next = LAST_B;
        end
    end

    // Stage k holds the tag of the read whose address was on the port k cycles ago.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            tag_valid_reg <= '0;
            tag_id_reg    <= '0;
        end else begin
            tag_valid_reg <= {tag_valid_reg[STAGES-2:0], gnt_a_next | gnt_b_next};
            tag_id_reg    <= {tag_id_reg[STAGES-2:0], gnt_b_next};
        end
    end

    assign ret_a = tag_valid_reg[RD_LATENCY] && !tag_id_reg[RD_LATENCY];
    assign ret_b = tag_valid_reg[RD_LATENCY] &&  tag_id_reg[RD_LATENCY];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rdata_a_reg  <= '0;
            rdata_b_reg  <= '0;
            rvalid_a_reg <= 1'b0;
            rvalid_b_reg <= 1'b0;
        end else begin
            rvalid_a_reg <= ret_a;
            rvalid_b_reg <= ret_b;
            if (ret_a) begin
                rdata_a_reg <= mem_rdata;
            end
            if (ret_b) begin
                rdata_b_reg <= mem_rdata;
            end
        end
    end

    assign port_a.gnt    = gnt_a_reg;
    assign port_b.gnt    = gnt_b_reg;
    assign port_a.rdata  = rdata_a_reg;
    assign port_b.rdata  = rdata_b_reg;
    assign port_a.rvalid = rvalid_a_reg;
    assign port_b.rvalid = rvalid_b_reg;
    assign mem_addr      = mem_addr_reg;
    assign mem_en        = mem_en_reg;
endmodule

// File: tb/tb_worldmap_port_arbiter.sv
// Directed and scoreboarded checks of worldmap_port_arbiter at read latencies 1 and 3,
// each against a world-map model whose pixel value is addr[1:0].
module tb_worldmap_port_arbiter;
    localparam int ADDR_W = 14;
    localparam int DATA_W = 2;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    worldmap_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) a1_if ();
    worldmap_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) b1_if ();
    worldmap_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) a3_if ();
    worldmap_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) b3_if ();

    logic [ADDR_W-1:0] mem_addr1, mem_addr3;
    logic              mem_en1, mem_en3;
    logic [DATA_W-1:0] mem_rdata1, mem_rdata3;

    // World-map models: registered read of depth 1 and 3.
    logic [DATA_W-1:0] m1_q;
    logic [DATA_W-1:0] m3_q [0:2];
    always @(posedge clock) begin
        m1_q    <= mem_addr1[1:0];
        m3_q[0] <= mem_addr3[1:0];
        m3_q[1] <= m3_q[0];
        m3_q[2] <= m3_q[1];
    end
    assign mem_rdata1 = m1_q;
    assign mem_rdata3 = m3_q[2];

    worldmap_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LATENCY(1)) dut1 (
        .clock(clock), .reset_n(reset_n), .port_a(a1_if), .port_b(b1_if),
        .mem_addr(mem_addr1), .mem_en(mem_en1), .mem_rdata(mem_rdata1)
    );
    worldmap_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LATENCY(3)) dut3 (
        .clock(clock), .reset_n(reset_n), .port_a(a3_if), .port_b(b3_if),
        .mem_addr(mem_addr3), .mem_en(mem_en3), .mem_rdata(mem_rdata3)
    );

    int checks = 0;
    int passed = 0;
    int fails  = 0;

    int          cyc;
    logic        exp_ga, exp_gb, exp_last, nga, ngb, ea, eb;
    int          due_a[$];
    int          due_b[$];
    logic [1:0]  dat_a[$];
    logic [1:0]  dat_b[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " dut1 gnt"},    {a1_if.gnt, b1_if.gnt}, 0);
        chk({tag, " dut1 rvalid"}, {a1_if.rvalid, b1_if.rvalid}, 0);
        chk({tag, " dut1 rdata"},  {a1_if.rdata, b1_if.rdata}, 0);
        chk({tag, " dut1 mem"},    {mem_en1, mem_addr1}, 0);
        chk({tag, " dut3 gnt"},    {a3_if.gnt, b3_if.gnt}, 0);
        chk({tag, " dut3 rvalid"}, {a3_if.rvalid, b3_if.rvalid}, 0);
        chk({tag, " dut3 rdata"},  {a3_if.rdata, b3_if.rdata}, 0);
        chk({tag, " dut3 mem"},    {mem_en3, mem_addr3}, 0);
    endtask

    initial begin
        a1_if.req = 0; a1_if.addr = '0; b1_if.req = 0; b1_if.addr = '0;
        a3_if.req = 0; a3_if.addr = '0; b3_if.req = 0; b3_if.addr = '0;
        repeat (3) step();
        chk_zero("reset");

        // Single requester A held high: granted every other cycle.
        a1_if.addr = 14'h0081; a1_if.req = 1;
        reset_n = 1;
        for (int c = 1; c <= 8; c++) begin
            step();
            chk($sformatf("t1 gnt_a c%0d", c), a1_if.gnt, c % 2);
            chk($sformatf("t1 gnt_b c%0d", c), b1_if.gnt, 0);
            chk($sformatf("t1 mem_en c%0d", c), mem_en1, c % 2);
            chk($sformatf("t1 mem_addr c%0d", c), mem_addr1, 14'h0081);
            chk($sformatf("t1 rvalid_a c%0d", c), a1_if.rvalid, (c >= 3 && c % 2 == 1));
            if (c >= 3 && c % 2 == 1) chk($sformatf("t1 rdata_a c%0d", c), a1_if.rdata, 2'b01);
        end
        a1_if.req = 0;
        step();
        chk("t1 drop gnt_a", a1_if.gnt, 0);
        chk("t1 last rvalid_a", a1_if.rvalid, 1);
        step();

        // Both requesters from the same edge after reset: A first, then alternate.
        reset_n = 0;
        step();
        a1_if.addr = 14'h1002; a1_if.req = 1;
        b1_if.addr = 14'h2003; b1_if.req = 1;
        reset_n = 1;
        for (int c = 1; c <= 8; c++) begin
            step();
            chk($sformatf("t2 gnt_a c%0d", c), a1_if.gnt, c % 2);
            chk($sformatf("t2 gnt_b c%0d", c), b1_if.gnt, (c % 2 == 0));
            chk($sformatf("t2 excl c%0d", c), a1_if.gnt & b1_if.gnt, 0);
            chk($sformatf("t2 mem_en c%0d", c), mem_en1, 1);
            chk($sformatf("t2 mem_addr c%0d", c), mem_addr1, (c % 2 == 1) ? 14'h1002 : 14'h2003);
            chk($sformatf("t2 rvalid_a c%0d", c), a1_if.rvalid, (c >= 3 && c % 2 == 1));
            chk($sformatf("t2 rvalid_b c%0d", c), b1_if.rvalid, (c >= 4 && c % 2 == 0));
            if (c >= 3 && c % 2 == 1) chk($sformatf("t2 rdata_a c%0d", c), a1_if.rdata, 2);
            if (c >= 4 && c % 2 == 0) chk($sformatf("t2 rdata_b c%0d", c), b1_if.rdata, 3);
        end

        // Idle after traffic: port quiet, address and returned data hold.
        a1_if.req = 0; b1_if.req = 0;
        step();
        chk("t6 mem_en c9", mem_en1, 0);
        chk("t6 rvalid_a c9", {a1_if.rvalid, a1_if.rdata}, {1'b1, 2'd2});
        step();
        chk("t6 rvalid_b c10", {b1_if.rvalid, b1_if.rdata}, {1'b1, 2'd3});
        for (int c = 11; c <= 16; c++) begin
            step();
            chk($sformatf("t6 gnt c%0d", c), {a1_if.gnt, b1_if.gnt, mem_en1}, 0);
            chk($sformatf("t6 mem_addr c%0d", c), mem_addr1, 14'h2003);
            chk($sformatf("t6 rvalid c%0d", c), {a1_if.rvalid, b1_if.rvalid}, 0);
            chk($sformatf("t6 rdata c%0d", c), {a1_if.rdata, b1_if.rdata}, {2'd2, 2'd3});
        end

        // One-cycle req_b pulse while A holds the port.
        a1_if.addr = 14'h0005; a1_if.req = 1;
        step();
        chk("t5 c1 gnt_a", {a1_if.gnt, b1_if.gnt}, 2'b10);
        chk("t5 c1 mem_addr", mem_addr1, 14'h0005);
        b1_if.addr = 14'h000A; b1_if.req = 1;
        step();
        chk("t5 c2 gnt_b", {a1_if.gnt, b1_if.gnt}, 2'b01);
        chk("t5 c2 mem_addr", mem_addr1, 14'h000A);
        b1_if.req = 0;
        step();
        chk("t5 c3 gnt_a", {a1_if.gnt, b1_if.gnt}, 2'b10);
        chk("t5 c3 rvalid_a", {a1_if.rvalid, a1_if.rdata}, {1'b1, 2'd1});
        step();
        chk("t5 c4 gnt", {a1_if.gnt, b1_if.gnt}, 2'b00);
        chk("t5 c4 rvalid_b", {b1_if.rvalid, b1_if.rdata}, {1'b1, 2'd2});
        step();
        chk("t5 c5 gnt_a", {a1_if.gnt, a1_if.rvalid}, 2'b11);
        // Request raised and withdrawn between edges is never seen.
        b1_if.addr = 14'h3FFF; b1_if.req = 1;
        #2;
        b1_if.req = 0;
        for (int c = 6; c <= 11; c++) begin
            step();
            chk($sformatf("t5 withdrawn gnt_b c%0d", c), b1_if.gnt, 0);
            chk($sformatf("t5 withdrawn rvalid_b c%0d", c), b1_if.rvalid, 0);
            chk($sformatf("t5 gnt_a c%0d", c), a1_if.gnt, c % 2);
        end
        chk("t5 rdata_b hold", b1_if.rdata, 2);
        a1_if.req = 0;
        step();
        step();

        // Reset while reads are in flight discards their tags.
        a1_if.addr = 14'h0102; a1_if.req = 1;
        a3_if.addr = 14'h0102; a3_if.req = 1;
        step();
        chk("t4 c1 gnt_a", {a1_if.gnt, a3_if.gnt}, 2'b11);
        a1_if.req = 0; a3_if.req = 0;
        b1_if.addr = 14'h0203; b1_if.req = 1;
        b3_if.addr = 14'h0203; b3_if.req = 1;
        step();
        chk("t4 c2 gnt_b", {b1_if.gnt, b3_if.gnt}, 2'b11);
        b1_if.req = 0; b3_if.req = 0;
        step();
        chk("t4 c3 dut1 rvalid_a", {a1_if.rvalid, a1_if.rdata}, {1'b1, 2'd2});
        reset_n = 0;
        #1;
        chk_zero("t4 async");
        step();
        reset_n = 1;
        for (int k = 1; k <= 8; k++) begin
            step();
            chk($sformatf("t4 post dut1 k%0d", k), {a1_if.rvalid, b1_if.rvalid, a1_if.gnt, b1_if.gnt}, 0);
            chk($sformatf("t4 post dut3 k%0d", k), {a3_if.rvalid, b3_if.rvalid, a3_if.gnt, b3_if.gnt}, 0);
        end

        // Random interleaved traffic at latency 3 against an arbiter model and scoreboard.
        exp_ga = 0; exp_gb = 0; exp_last = 1; cyc = 0;
        for (int n = 0; n < 10000; n++) begin
            if (exp_ga || !a3_if.req) begin
                a3_if.req  = ($urandom_range(0, 3) != 0);
                a3_if.addr = 14'($urandom);
            end
            if (exp_gb || !b3_if.req) begin
                b3_if.req  = ($urandom_range(0, 3) != 0);
                b3_if.addr = 14'($urandom);
            end
            ea  = a3_if.req && !exp_ga;
            eb  = b3_if.req && !exp_gb;
            nga = ea && (!eb || exp_last);
            ngb = eb && !nga;
            if (nga) exp_last = 0;
            else if (ngb) exp_last = 1;
            step();
            cyc++;
            exp_ga = nga; exp_gb = ngb;
            chk($sformatf("t3 gnt c%0d", cyc), {a3_if.gnt, b3_if.gnt, mem_en3}, {nga, ngb, nga | ngb});
            if (nga) begin
                chk($sformatf("t3 mem_addr_a c%0d", cyc), mem_addr3, a3_if.addr);
                due_a.push_back(cyc + 4); dat_a.push_back(a3_if.addr[1:0]);
            end
            if (ngb) begin
                chk($sformatf("t3 mem_addr_b c%0d", cyc), mem_addr3, b3_if.addr);
                due_b.push_back(cyc + 4); dat_b.push_back(b3_if.addr[1:0]);
            end
            if (due_a.size() > 0 && due_a[0] == cyc) begin
                chk($sformatf("t3 ret_a c%0d", cyc), {a3_if.rvalid, a3_if.rdata}, {1'b1, dat_a[0]});
                void'(due_a.pop_front()); void'(dat_a.pop_front());
            end else chk($sformatf("t3 rvalid_a c%0d", cyc), a3_if.rvalid, 0);
            if (due_b.size() > 0 && due_b[0] == cyc) begin
                chk($sformatf("t3 ret_b c%0d", cyc), {b3_if.rvalid, b3_if.rdata}, {1'b1, dat_b[0]});
                void'(due_b.pop_front()); void'(dat_b.pop_front());
            end else chk($sformatf("t3 rvalid_b c%0d", cyc), b3_if.rvalid, 0);
        end
        a3_if.req = 0; b3_if.req = 0;
        for (int n = 0; n < 6; n++) begin
            step();
            cyc++;
            chk($sformatf("t3 drain gnt c%0d", cyc), {a3_if.gnt, b3_if.gnt}, 0);
            if (due_a.size() > 0 && due_a[0] == cyc) begin
                chk($sformatf("t3 drain ret_a c%0d", cyc), {a3_if.rvalid, a3_if.rdata}, {1'b1, dat_a[0]});
                void'(due_a.pop_front()); void'(dat_a.pop_front());
            end else chk($sformatf("t3 drain rvalid_a c%0d", cyc), a3_if.rvalid, 0);
            if (due_b.size() > 0 && due_b[0] == cyc) begin
                chk($sformatf("t3 drain ret_b c%0d", cyc), {b3_if.rvalid, b3_if.rdata}, {1'b1, dat_b[0]});
                void'(due_b.pop_front()); void'(dat_b.pop_front());
            end else chk($sformatf("t3 drain rvalid_b c%0d", cyc), b3_if.rvalid, 0);
        end
        chk("t3 outstanding", due_a.size() + due_b.size(), 0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
